param_alu: RTL

PARAM_ALU -- requirements
Module: param_alu

---
 rtl/param_alu_pkg.sv | 23 ++
 rtl/seq_mult.sv | 61 ++++++
 rtl/param_alu.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/param_alu_pkg.sv
// param_alu_pkg
// Shared definitions for the parameterised ALU: opcode encodings and the
// control FSM state encoding.
package param_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult.sv
// seq_mult
// Unsigned shift-add multiplier, one partial-product step per clock,
// WIDTH steps per operation.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - load a/b and begin a new multiplication
//   a, b      - WIDTH-bit unsigned operands
//   done      - high during the cycle whose step is the last one
//   product   - 2*WIDTH-bit product; exact when done is high
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;

  // The product is presented from the accumulator's next value so the
  // caller can capture the finished result on the same edge as the last step.
  assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign product  = acc_next;
  assign done     = busy_reg && (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CW'(1);
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/param_alu.sv
// param_alu
// Parameterised ALU with valid/ready handshakes. Single-cycle ops finish one
// cycle after acceptance; MUL runs on a sequential multiplier for WIDTH cycles.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   A, B, opcode          - request operands and operation
//   in_valid / in_ready   - request handshake (ready only in IDLE)
//   res, carry, zero, ovf - registered result and flags
//   out_valid / out_ready - result handshake (result held until taken)
module param_alu
  import param_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e state_reg, state_next;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic             zero_reg;
  logic             ovf_reg;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (opcode == OP_MUL) ? S_EXEC : S_DONE;
        end
      end
      S_EXEC: begin
        if (mul_done) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Single-cycle datapath. diff[WIDTH] is the unsigned borrow, i.e. A < B.
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOT: alu_res = ~A;
      OP_CMP: begin
        alu_res   = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
        alu_carry = diff[WIDTH];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Result registers: loaded at acceptance for single-cycle ops, or on the
  // final multiplier step for MUL; held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_reg   <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept && (opcode != OP_MUL)) begin
      res_reg   <= alu_res;
      carry_reg <= alu_carry;
      zero_reg  <= (alu_res == '0);
      ovf_reg   <= alu_ovf;
    end else if ((state_reg == S_EXEC) && mul_done) begin
      res_reg   <= mul_product[WIDTH-1:0];
      carry_reg <= |mul_product[2*WIDTH-1:WIDTH];
      zero_reg  <= (mul_product[WIDTH-1:0] == '0);
      ovf_reg   <= 1'b0;
    end
  end

  assign res   = res_reg;
  assign carry = carry_reg;
  assign zero  = zero_reg;
  assign ovf   = ovf_reg;

endmodule
